// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared types and sizing defaults for the systolic feed scheduler.
package systolic_pkg;

    localparam int N_DEFAULT = 32;
    localparam int M_DEFAULT = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Enabled cycles needed for the last product to reach the far corner PE.
    function automatic int run_cycles(input int m);
        return 3 * m - 2;
    endfunction

    localparam int RUN_CYCLES = run_cycles(M_DEFAULT);

endpackage

// File: rtl/systolic_feed_scheduler_if.sv
// Bundle between the operand memories, the systolic array and the scheduler.
interface systolic_feed_scheduler_if
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int AW = (M > 1) ? $clog2(M) : 1
);
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [M*N-1:0]  a_rdata;
    logic [M*N-1:0]  b_rdata;
    logic            arr_clr;
    logic            arr_en;
    logic [M*N-1:0]  a_flat;
    logic [M*N-1:0]  b_flat;

    modport master (
        input  start, abort, a_rdata, b_rdata,
        output busy, done, mem_rd, mem_addr, arr_clr, arr_en, a_flat, b_flat
    );

    modport slave (
        output start, abort, a_rdata, b_rdata,
        input  busy, done, mem_rd, mem_addr, arr_clr, arr_en, a_flat, b_flat
    );
endinterface

// File: rtl/systolic_feed_scheduler_skew_line.sv
// DEPTH-stage registered delay line with async zero reset and synchronous flush.
module skew_line #(
    parameter int N     = 32,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] dout_o
);
    logic [DEPTH-1:0][N-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (clr_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];
endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequences one MxM output-stationary multiply: clear, operand fetch, diagonal
// skew into the array, enable window and a one-cycle done pulse.
module systolic_feed_scheduler
    import systolic_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                       clk,
    input  logic                       init_n,
    systolic_feed_scheduler_if.master  bus
);
    localparam int RUN_LEN = run_cycles(M);
    localparam int CW      = $clog2(3 * M);

    state_e          state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic            arr_en_q, arr_en_d;
    logic            flush;
    logic [M*N-1:0]  a_in, b_in;
    logic [M*N-1:0]  a_out, b_out;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            arr_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            arr_en_q   <= arr_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rd_valid_d = (state_q == FEED);
        arr_en_d   = arr_en_q;
        flush      = 1'b0;

        case (state_q)
            IDLE:  if (bus.start) state_d = CLEAR;
            CLEAR: begin
                state_d = FEED;
                k_d     = '0;
            end
            FEED: begin
                k_d = k_q + 1'b1;
                if (k_q == AW'(M - 1)) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end
            end
            DRAIN: if (arr_en_q && cnt_q == CW'(RUN_LEN - 1)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Enable window opens on the first valid read word and closes after RUN_LEN cycles.
        if (arr_en_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(RUN_LEN - 1)) arr_en_d = 1'b0;
        end else if (rd_valid_q && cnt_q == '0) begin
            arr_en_d = 1'b1;
        end
        if (state_q == DONE) cnt_d = '0;

        if (bus.abort && state_q != IDLE) begin
            state_d    = IDLE;
            k_d        = '0;
            cnt_d      = '0;
            rd_valid_d = 1'b0;
            arr_en_d   = 1'b0;
            flush      = 1'b1;
        end
    end

    assign a_in = rd_valid_q ? bus.a_rdata : '0;
    assign b_in = rd_valid_q ? bus.b_rdata : '0;

    for (genvar gi = 0; gi < M; gi++) begin : g_lane
        skew_line #(.N(N), .DEPTH(gi + 1)) u_a_line (
            .clk    (clk),
            .rst_n  (init_n),
            .clr_i  (flush),
            .din_i  (a_in[gi*N +: N]),
            .dout_o (a_out[gi*N +: N])
        );
        skew_line #(.N(N), .DEPTH(gi + 1)) u_b_line (
            .clk    (clk),
            .rst_n  (init_n),
            .clr_i  (flush),
            .din_i  (b_in[gi*N +: N]),
            .dout_o (b_out[gi*N +: N])
        );
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.arr_clr  = (state_q == CLEAR);
    assign bus.mem_rd   = (state_q == FEED);
    assign bus.mem_addr = (state_q == FEED) ? k_q : '0;
    assign bus.arr_en   = arr_en_q;
    assign bus.a_flat   = a_out;
    assign bus.b_flat   = b_out;
endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Scoreboard bench: the driver pushes skew-formula expectations per run, a
// negedge monitor pops and compares whatever the scheduler presents.
module tb_systolic_feed_scheduler;
    localparam int N   = 32;
    localparam int M   = 5;
    localparam int RUN = 3 * M - 2;
    localparam int LAT = 3 * M + 2;
    localparam int PER = 3 * M + 3;

    typedef struct {
        int             cyc;
        logic [M*N-1:0] a;
        logic [M*N-1:0] b;
    } beat_t;

    logic clk = 1'b0;
    logic init_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    beat_t exp_q[$];
    int    clr_q[$];
    int    done_q[$];

    logic [N-1:0] amem [M][M];
    logic [N-1:0] bmem [M][M];

    systolic_feed_scheduler_if #(.N(N), .M(M)) bus ();
    systolic_feed_scheduler #(.N(N), .M(M)) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: one-cycle read latency, junk on the bus otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < M; i++) begin
            if (bus.mem_rd) begin
                bus.a_rdata[i*N +: N] <= amem[i][bus.mem_addr];
                bus.b_rdata[i*N +: N] <= bmem[bus.mem_addr][i];
            end else begin
                bus.a_rdata[i*N +: N] <= N'($urandom);
                bus.b_rdata[i*N +: N] <= N'($urandom);
            end
        end
    end

    task automatic check(input string name, input logic [M*N-1:0] act, input logic [M*N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.arr_clr) begin
            check_int("clr_cycle", cyc, (clr_q.size() > 0) ? clr_q.pop_front() : -1);
        end
        if (bus.arr_en) begin
            beat_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
                e.cyc = -1; e.a = '0; e.b = '0;
            end
            check_int("en_cycle", cyc, e.cyc);
            check("a_flat", bus.a_flat, e.a);
            check("b_flat", bus.b_flat, e.b);
        end else begin
            check("a_flat_idle", bus.a_flat, '0);
            check("b_flat_idle", bus.b_flat, '0);
        end
        if (bus.done) begin
            int exp_c;
            exp_c = (done_q.size() > 0) ? done_q.pop_front() : -1;
            check_int("done_cycle", cyc, exp_c);
            n_done++;
            $display("run %0d: done at cycle %0d (expected %0d)", n_done, cyc, exp_c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_exp();
        exp_q.delete();
        clr_q.delete();
        done_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, (M*N)'({bus.busy, bus.done, bus.mem_rd, bus.arr_clr, bus.arr_en, bus.mem_addr}), '0);
        check({tag, "_a"}, bus.a_flat, '0);
        check({tag, "_b"}, bus.b_flat, '0);
    endtask

    // mode 0: random, 1: identity, 2: A[i][k]=10i+k, B[k][j]=10k+j
    task automatic fill(input int mode);
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                case (mode)
                    1: begin amem[r][c] = N'(r == c); bmem[r][c] = N'(r == c); end
                    2: begin amem[r][c] = N'(10 * r + c); bmem[r][c] = N'(10 * r + c); end
                    default: begin amem[r][c] = N'($urandom); bmem[r][c] = N'($urandom); end
                endcase
            end
        end
    endtask

    // Expected array feed for a start accepted at the end of cycle s.
    task automatic push_run(input int s);
        for (int t = 0; t < RUN; t++) begin
            beat_t e;
            e.cyc = s + 4 + t;
            e.a = '0;
            e.b = '0;
            for (int i = 0; i < M; i++) begin
                if (t - i >= 0 && t - i < M) begin
                    e.a[i*N +: N] = amem[i][t-i];
                    e.b[i*N +: N] = bmem[t-i][i];
                end
            end
            exp_q.push_back(e);
        end
        clr_q.push_back(s + 1);
        done_q.push_back(s + LAT);
    endtask

    // One run; a stray start pulse at offset extra (0 = none) must be ignored.
    task automatic run(input int extra);
        int s;
        s = cyc;
        bus.start = 1'b1;
        push_run(s);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            bus.start = (c == extra);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_cont();
        int s;
        s = cyc;
        bus.start = 1'b1;
        push_run(s);
        push_run(s + PER);
        repeat (PER) tick();
        tick();
        bus.start = 1'b0;
        repeat (PER - 1) tick();
    endtask

    task automatic run_abort(input int off);
        int s;
        s = cyc;
        bus.start = 1'b1;
        push_run(s);
        for (int c = 1; c <= off; c++) begin
            tick();
            bus.start = 1'b0;
            bus.abort = (c == off);
        end
        tick();
        bus.abort = 1'b0;
        flush_exp();
        check_zero("abort");
        tick();
    endtask

    task automatic run_reset(input int off);
        int s;
        s = cyc;
        bus.start = 1'b1;
        push_run(s);
        for (int c = 1; c <= off; c++) begin
            tick();
            bus.start = 1'b0;
        end
        #2 init_n = 1'b0;
        #1;
        flush_exp();
        check_zero("async_reset");
        tick();
        tick();
        #2 init_n = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        init_n = 1'b0;
        fill(0);
        repeat (2) tick();
        check_zero("reset");
        #2 init_n = 1'b1;
        tick();

        fill(1); run(0);
        fill(2); run(0);
        fill(2); run(3);
        fill(0); run(LAT);
        fill(0); run_cont();
        fill(0); run_abort(4);
        fill(2); run(0);
        fill(0); run_reset(10);
        fill(0); run(0);

        for (int n = 0; n < 10; n++) begin
            int op;
            fill(0);
            repeat ($urandom_range(0, 3)) tick();
            op = $urandom_range(0, 3);
            case (op)
                2:       run_abort($urandom_range(1, LAT));
                3:       run_reset($urandom_range(1, LAT));
                default: run($urandom_range(0, LAT));
            endcase
        end

        repeat (5) tick();
        check_int("leftover_beats", exp_q.size(), 0);
        check_int("leftover_clr", clr_q.size(), 0);
        check_int("leftover_done", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
